remainder_multiplier: RTL and testbench
=======================================

// Module: remainder_multiplier
// PURPOSE
//  Sequential shift-add multiply-accumulate: P = Q*B + R. Inverse of the
//  repeated-subtraction divider: it reconstructs the dividend from
//  quotient/divisor/remainder. Used as a divider checker and as a standalone
//  multiplier (R=0). Shares the start/done handshake with the divider.
// PARAMETERS
//  WIDTH   32   width of Q, B, R; P is 2*WIDTH
// PORTS
//  Clk      in   1          clock; all state updates on rising edge
//  Rst      in   1          synchronous, active-low reset (sampled on Clk)
//  start    in   1          request; sampled only in IDLE
//  Q        in   WIDTH      quotient / multiplier operand
//  B        in   WIDTH      divisor / multiplicand operand
//  R        in   WIDTH      remainder / addend
//  P        out  2*WIDTH    result Q*B+R, registered
//  ovf      out  1          1 when P >= 2**WIDTH (does not fit divider's A)
//  rem_err  out  1          1 when R >= B (not a legal remainder; includes B=0)
//  busy     out  1          1 in CALC
//  done     out  1          1 in DONE
// BEHAVIOUR
//  Reset (Rst=0 at edge): state=IDLE; P, ovf, rem_err, busy, done=0; internal
//   acc/mb/mq/cnt=0. Reset wins over every other condition, including mid-CALC.
//  States: IDLE, CALC, DONE (2-bit encoding; unused code -> IDLE next edge).
//  IDLE: outputs busy=0, done=0; P/ovf/rem_err keep the last result.
//   start=1 at edge k -> acc={WIDTH'b0,R}, mb={WIDTH'b0,B}, mq=Q, cnt=0,
//   rem_err<=(R>=B), state=CALC. Q/B/R are captured only at this edge.
//  CALC: each edge: if mq[0], acc<=acc+mb; mb<=mb<<1; mq<=mq>>1; cnt<=cnt+1.
//   Fixed latency, no early exit when mq==0: exactly WIDTH iterations
//   (edges k+1..k+WIDTH). On the edge where cnt==WIDTH-1: P<=final acc,
//   ovf<=|final_acc[2*WIDTH-1:WIDTH], state=DONE.
//   start is ignored while in CALC. Operand changes are ignored.
//  DONE: done=1, busy=0, P/ovf/rem_err stable. Stay while start=1;
//   start=0 at edge -> IDLE. A new operation requires a start low-high.
//  Latency: done first high after edge k+WIDTH (WIDTH+1 edges incl. load).
//  Arithmetic: max Q*B+R = (2**W-1)**2 + 2**W-1 < 2**(2W); acc never wraps.
//  rem_err is advisory only; the multiply still completes and P is valid.
//  busy and done are never 1 together; P changes only on the DONE-entry edge.
// TESTING (bench runs WIDTH=8 plus one WIDTH=32 smoke run)
//  1 Q=13,B=7,R=5, start 1 cycle -> done after 9 edges, P=96, ovf=0,
//    rem_err=0; busy high for exactly 8 cycles.
//  2 Q=255,B=255,R=254 -> P=65279 (0xFEFF), ovf=1, rem_err=0.
//  3 Q=0,B=0,R=0 -> P=0, ovf=0, rem_err=1; latency still 9 edges.
//  4 Rst=0 at 4th CALC edge -> next edge IDLE, all outputs 0; new start
//    with Q=3,B=4,R=1 -> P=13.
//  5 start held high through DONE 5 cycles -> done stays 1, P stable;
//    drop start -> IDLE next edge; operand change during CALC -> P unchanged.
//  6 Random 1000 (Q,B,R) with R<B at WIDTH=32 -> P==Q*B+R; feed P back
//    through the divider -> recovered quotient Q and remainder R match.

Source files
------------

// File: rtl/remainder_multiplier.sv
// remainder_multiplier: sequential shift-add multiply-accumulate, P = Q*B + R.
// Rebuilds a dividend from quotient/divisor/remainder, so it can check the
// repeated-subtraction divider. With R=0 it is a plain multiplier. It uses the
// same start/done handshake as the divider.
module remainder_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     Q,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-1:0]     R,
   output logic [2*WIDTH-1:0]   P,
   output logic                 ovf,
   output logic                 rem_err,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned      CW   = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state;
   logic [2*WIDTH-1:0]  acc;
   logic [2*WIDTH-1:0]  mb;
   logic [2*WIDTH-1:0]  acc_next;
   logic [WIDTH-1:0]    mq;
   logic [CW-1:0]       cnt;

   // Accumulator value after the current iteration: add the shifted multiplicand
   // when the current multiplier bit is set.
   always_comb begin
      acc_next = acc;
      if (mq[0]) acc_next = acc + mb;
   end

   // Control FSM and datapath registers. All outputs are registered, and reset wins.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state   <= S_IDLE;
         acc     <= '0;
         mb      <= '0;
         mq      <= '0;
         cnt     <= '0;
         P       <= '0;
         ovf     <= 1'b0;
         rem_err <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  acc     <= {{WIDTH{1'b0}}, R};
                  mb      <= {{WIDTH{1'b0}}, B};
                  mq      <= Q;
                  cnt     <= '0;
                  rem_err <= (R >= B);
                  busy    <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               acc <= acc_next;
               mb  <= mb << 1;
               mq  <= mq >> 1;
               cnt <= cnt + 1'b1;
               // The last iteration takes its sum straight from acc_next. This
               // keeps the latency fixed at WIDTH edges and needs no extra state.
               if (cnt == LAST) begin
                  P     <= acc_next;
                  ovf   <= |acc_next[2*WIDTH-1:WIDTH];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_remainder_multiplier.sv
// Testbench for remainder_multiplier. It runs a WIDTH=8 instance for the
// directed and random scenarios, and a WIDTH=32 instance for the random
// multiply and divider-recovery run. Expected values come from plain
// integer arithmetic.
module tb_remainder_multiplier;

   logic         clk = 1'b0;
   logic         rst = 1'b0;

   logic         start8 = 1'b0;
   logic [7:0]   q8 = '0, b8 = '0, r8 = '0;
   logic [15:0]  p8;
   logic         ovf8, rem_err8, busy8, done8;

   logic         start32 = 1'b0;
   logic [31:0]  q32 = '0, b32 = '0, r32 = '0;
   logic [63:0]  p32;
   logic         ovf32, rem_err32, busy32, done32;

   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   remainder_multiplier #(.WIDTH(8)) dut8 (
      .Clk(clk), .Rst(rst), .start(start8), .Q(q8), .B(b8), .R(r8),
      .P(p8), .ovf(ovf8), .rem_err(rem_err8), .busy(busy8), .done(done8)
   );

   remainder_multiplier #(.WIDTH(32)) dut32 (
      .Clk(clk), .Rst(rst), .start(start32), .Q(q32), .B(b32), .R(r32),
      .P(p32), .ovf(ovf32), .rem_err(rem_err32), .busy(busy32), .done(done32)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one 8-bit operation and wait until done, with a cycle limit.
   // The task reports the edge count (load edge included), the number of busy
   // cycles, how often P moved before done, and any busy/done overlap.
   task automatic run8(input logic [7:0] qa, input logic [7:0] ba, input logic [7:0] ra,
                       input bit hold, input bit scramble,
                       output int edges, output int busy_cycles,
                       output int p_moves, output int overlap);
      logic [15:0] p_prev;
      p_prev = p8;
      q8 = qa; b8 = ba; r8 = ra;
      start8 = 1'b1;
      tick();
      if (!hold) start8 = 1'b0;
      if (scramble) begin
         q8 = 8'($urandom); b8 = 8'($urandom); r8 = 8'($urandom);
      end
      edges = 1; busy_cycles = 0; p_moves = 0; overlap = 0;
      while (done8 !== 1'b1 && edges < 40) begin
         if (busy8 === 1'b1) busy_cycles++;
         if (busy8 === 1'b1 && done8 === 1'b1) overlap++;
         if (p8 !== p_prev) p_moves++;
         tick();
         edges++;
      end
      if (busy8 === 1'b1 && done8 === 1'b1) overlap++;
   endtask

   task automatic run32(input logic [31:0] qa, input logic [31:0] ba, input logic [31:0] ra,
                        output int edges);
      q32 = qa; b32 = ba; r32 = ra;
      start32 = 1'b1;
      tick();
      start32 = 1'b0;
      edges = 1;
      while (done32 !== 1'b1 && edges < 80) begin
         tick();
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      tests++;
      if ({p8, ovf8, rem_err8, busy8, done8} !== 20'h0) begin
         fails++; $display("FAIL reset8: got %h expected 0", {p8, ovf8, rem_err8, busy8, done8});
      end
      tests++;
      if ({p32, ovf32, rem_err32, busy32, done32} !== 68'h0) begin
         fails++; $display("FAIL reset32: got %h expected 0", {p32, ovf32, rem_err32, busy32, done32});
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int e, bc, pm, ov;
      run8(8'd13, 8'd7, 8'd5, 1'b0, 1'b0, e, bc, pm, ov);
      tests++;
      if (e !== 9) begin fails++; $display("FAIL basic_latency: got %0d expected 9", e); end
      tests++;
      if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
      tests++;
      if (p8 !== 16'd96) begin fails++; $display("FAIL basic_p: got %0d expected 96", p8); end
      tests++;
      if ({ovf8, rem_err8} !== 2'b00) begin fails++; $display("FAIL basic_flags: got %b expected 00", {ovf8, rem_err8}); end
      tests++;
      if (pm !== 0 || ov !== 0) begin fails++; $display("FAIL basic_p_stable_overlap: got %0d/%0d expected 0/0", pm, ov); end
      tick();
      tests++;
      if ({busy8, done8} !== 2'b00) begin fails++; $display("FAIL basic_return_idle: got %b expected 00", {busy8, done8}); end
   endtask

   task automatic test_zero();
      int e, bc, pm, ov;
      run8(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, e, bc, pm, ov);
      tests++;
      if (e !== 9) begin fails++; $display("FAIL zero_latency: got %0d expected 9", e); end
      tests++;
      if ({p8, ovf8, rem_err8} !== {16'd0, 1'b0, 1'b1}) begin
         fails++; $display("FAIL zero_result: got p=%0d ovf=%b rem_err=%b expected p=0 ovf=0 rem_err=1", p8, ovf8, rem_err8);
      end
      tick();
   endtask

   task automatic test_max();
      int e, bc, pm, ov;
      run8(8'd255, 8'd255, 8'd254, 1'b0, 1'b0, e, bc, pm, ov);
      tests++;
      if ({p8, ovf8, rem_err8} !== {16'hFEFF, 1'b1, 1'b0}) begin
         fails++; $display("FAIL max_result: got p=%h ovf=%b rem_err=%b expected p=feff ovf=1 rem_err=0", p8, ovf8, rem_err8);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int e, bc, pm, ov;
      q8 = 8'd200; b8 = 8'd10; r8 = 8'd50;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      tests++;
      if ({busy8, rem_err8} !== 2'b11) begin fails++; $display("FAIL midreset_pre: got %b expected 11", {busy8, rem_err8}); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tests++;
      if ({p8, ovf8, rem_err8, busy8, done8} !== 20'h0) begin
         fails++; $display("FAIL midreset_outputs: got %h expected 0", {p8, ovf8, rem_err8, busy8, done8});
      end
      run8(8'd3, 8'd4, 8'd1, 1'b0, 1'b0, e, bc, pm, ov);
      tests++;
      if (p8 !== 16'd13 || e !== 9) begin fails++; $display("FAIL midreset_restart: got p=%0d edges=%0d expected p=13 edges=9", p8, e); end
      tick();
   endtask

   task automatic test_hold_start();
      int e, bc, pm, ov;
      run8(8'd13, 8'd7, 8'd5, 1'b1, 1'b0, e, bc, pm, ov);
      tests++;
      if (p8 !== 16'd96 || e !== 9) begin fails++; $display("FAIL hold_first: got p=%0d edges=%0d expected p=96 edges=9", p8, e); end
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if ({done8, busy8, p8} !== {1'b1, 1'b0, 16'd96}) begin
            fails++; $display("FAIL hold_done_stable: got done=%b busy=%b p=%0d expected done=1 busy=0 p=96", done8, busy8, p8);
         end
      end
      start8 = 1'b0;
      tick();
      tests++;
      if ({busy8, done8} !== 2'b00) begin fails++; $display("FAIL hold_release_idle: got %b expected 00", {busy8, done8}); end
      run8(8'd13, 8'd7, 8'd5, 1'b0, 1'b1, e, bc, pm, ov);
      tests++;
      if (p8 !== 16'd96) begin fails++; $display("FAIL operand_change: got %0d expected 96", p8); end
      tick();
   endtask

   task automatic test_random8();
      int e, bc, pm, ov;
      int unsigned qa, ba, ra, expect_p;
      for (int i = 0; i < 200; i++) begin
         qa = $urandom_range(255); ba = $urandom_range(255); ra = $urandom_range(255);
         expect_p = qa * ba + ra;
         run8(8'(qa), 8'(ba), 8'(ra), 1'b0, 1'b0, e, bc, pm, ov);
         tests++;
         if (p8 !== 16'(expect_p) || ovf8 !== (expect_p >= 256) || rem_err8 !== (ra >= ba) || e !== 9 || ov !== 0) begin
            fails++;
            $display("FAIL rand8 q=%0d b=%0d r=%0d: got p=%0d ovf=%b rem_err=%b edges=%0d expected p=%0d ovf=%b rem_err=%b edges=9",
                     qa, ba, ra, p8, ovf8, rem_err8, e, expect_p, (expect_p >= 256), (ra >= ba));
         end
         tick();
      end
   endtask

   task automatic test_random32();
      int e;
      longint unsigned qq, bb, rr, expect_p, q_rec, r_rec;
      for (int i = 0; i < 1000; i++) begin
         qq = 64'($urandom);
         bb = 64'($urandom);
         if (bb == 0) bb = 1;
         rr = 64'($urandom) % bb;
         expect_p = qq * bb + rr;
         run32(32'(qq), 32'(bb), 32'(rr), e);
         tests++;
         if (p32 !== expect_p || ovf32 !== (expect_p >= 64'h1_0000_0000) || rem_err32 !== 1'b0) begin
            fails++;
            $display("FAIL rand32 q=%0d b=%0d r=%0d: got p=%0d ovf=%b rem_err=%b expected p=%0d ovf=%b rem_err=0",
                     qq, bb, rr, p32, ovf32, rem_err32, expect_p, (expect_p >= 64'h1_0000_0000));
         end
         q_rec = p32 / bb;
         r_rec = p32 % bb;
         tests++;
         if (q_rec !== qq || r_rec !== rr) begin
            fails++; $display("FAIL divide_back: got q=%0d r=%0d expected q=%0d r=%0d", q_rec, r_rec, qq, rr);
         end
         if (i == 0) begin
            tests++;
            if (e !== 33) begin fails++; $display("FAIL latency32: got %0d expected 33", e); end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_max();
      test_reset_mid();
      test_hold_start();
      test_random8();
      test_random32();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
